// File: rtl/oscillator_phase_ctrl.sv
// oscillator_phase_ctrl
// Per-voice sample controller. On each accepted sample tick it hands the
// current phase and note period to a shared sequential divider. After a
// fixed latency it captures the quotient (phase*256)/period and emits one
// waveform-shaped 8-bit sample with a one-cycle valid strobe.
//
// Divider handshake: div_en is a one-cycle start pulse with no ready or
// acknowledge. dividend/divider are driven from the ISSUE cycle and held
// stable until the next ISSUE. quotient is sampled exactly DIV_LATENCY
// cycles after the div_en pulse. sample_valid is a one-cycle strobe, and
// the mixer cannot apply backpressure.

module oscillator_phase_ctrl #(
  parameter int unsigned DIV_LATENCY = 12
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        sample_tick,
  input  logic [15:0] note_period,
  input  logic [1:0]  wave_sel,
  output logic        div_en,
  output logic [15:0] dividend,
  output logic [15:0] divider,
  input  logic [7:0]  quotient,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int unsigned CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   phase_q, phase_d;
  logic [15:0]   per_q, per_d;
  logic [1:0]    sel_q, sel_d;
  logic          div_en_q, div_en_d;
  logic [15:0]   dividend_q, dividend_d;
  logic [15:0]   divider_q, divider_d;
  logic [7:0]    sample_q, sample_d;
  logic          sample_valid_q, sample_valid_d;
  logic          overrun_q, overrun_d;

  logic [16:0]   phase_inc;
  logic [15:0]   issue_phase;

  // Map the quotient (position within one waveform period) to the selected shape.
  function automatic logic [7:0] shape(input logic [7:0] q, input logic [1:0] sel);
    logic [7:0] r;
    case (sel)
      2'b00:   r = q;
      2'b01:   r = q[7] ? 8'h00 : 8'hFF;
      2'b10:   r = q[7] ? ~{q[6:0], 1'b0} : {q[6:0], 1'b0};
      default: r = ~q;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic for the tick -> issue -> wait -> output sequence.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    per_d          = per_q;
    sel_d          = sel_q;
    div_en_d       = 1'b0;
    dividend_d     = dividend_q;
    divider_d      = divider_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;

    // 17-bit increment so a period of 16'hFFFF wraps without overflow.
    phase_inc   = {1'b0, phase_q} + 17'd1;
    // If the period shrank below the running phase, restart the cycle.
    issue_phase = (phase_q >= note_period) ? 16'd0 : phase_q;

    // A tick outside IDLE is dropped and only flagged.
    if (sample_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          per_d = note_period;
          sel_d = wave_sel;
          if (note_period == 16'd0) begin
            // Silent voice: emit midscale immediately, no divider use.
            sample_d       = 8'h80;
            sample_valid_d = 1'b1;
            phase_d        = 16'd0;
          end else begin
            phase_d    = issue_phase;
            div_en_d   = 1'b1;
            dividend_d = issue_phase;
            divider_d  = note_period;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(DIV_LATENCY - 1);
        phase_d = (phase_inc == {1'b0, per_q}) ? 16'd0 : phase_inc[15:0];
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          sample_d       = shape(quotient, sel_q);
          sample_valid_d = 1'b1;
          state_d        = S_OUTPUT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      phase_q        <= 16'd0;
      per_q          <= 16'd0;
      sel_q          <= 2'b00;
      div_en_q       <= 1'b0;
      dividend_q     <= 16'd0;
      divider_q      <= 16'd0;
      sample_q       <= 8'h80;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      per_q          <= per_d;
      sel_q          <= sel_d;
      div_en_q       <= div_en_d;
      dividend_q     <= dividend_d;
      divider_q      <= divider_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign div_en       = div_en_q;
  assign dividend     = dividend_q;
  assign divider      = divider_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_oscillator_phase_ctrl.sv
// tb_oscillator_phase_ctrl
// Directed bench for oscillator_phase_ctrl with a behavioural model of the
// shared sequential divider (result valid only from 11 cycles after div_en).

module tb_oscillator_phase_ctrl;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] note_period = 16'd0;
  logic [1:0]  wave_sel = 2'b00;
  logic        div_en;
  logic [15:0] dividend;
  logic [15:0] divider;
  logic [7:0]  quotient = 8'hA5;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int dcnt = 100;

  oscillator_phase_ctrl #(.DIV_LATENCY(12)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .sample_tick  (sample_tick),
    .note_period  (note_period),
    .wave_sel     (wave_sel),
    .div_en       (div_en),
    .dividend     (dividend),
    .divider      (divider),
    .quotient     (quotient),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  // Clock
  always #5 clk = ~clk;

  // Divider model: garbage until 11 cycles after the start pulse.
  always @(negedge clk) begin
    logic [23:0] num;
    if (div_en) dcnt = 0;
    else if (dcnt < 100) dcnt = dcnt + 1;
    num = {dividend, 8'h00};
    if (dcnt >= 11 && divider != 16'd0) quotient = 8'(num / {8'h00, divider});
    else quotient = 8'hA5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
  endtask

  // Pulse a tick; returns at the negedge of cycle T+1.
  task automatic tick_once();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // One non-silent transaction: issue values, latency, single valid, sample.
  task automatic run_sample(input string tag, input logic [15:0] exp_div,
                            input logic [15:0] exp_per, input logic [7:0] exp_smp);
    int lat;
    int nval;
    logic [7:0] got_smp;
    lat = 0;
    nval = 0;
    got_smp = 8'h00;
    tick_once();
    check({tag, "_div_en"}, {31'd0, div_en}, 32'd1);
    check({tag, "_dividend"}, {16'd0, dividend}, {16'd0, exp_div});
    check({tag, "_divider"}, {16'd0, divider}, {16'd0, exp_per});
    for (int i = 2; i <= 19; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        nval++;
        if (lat == 0) begin
          lat = i;
          got_smp = sample;
        end
      end
    end
    check({tag, "_latency"}, lat, 32'd14);
    check({tag, "_nvalid"}, nval, 32'd1);
    check({tag, "_sample"}, {24'd0, got_smp}, {24'd0, exp_smp});
  endtask

  initial begin
    int nval;
    int nen;
    logic [7:0] got_smp;

    // Reset values
    nRst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_div_en", {31'd0, div_en}, 32'd0);
    check("rst_dividend", {16'd0, dividend}, 32'd0);
    check("rst_divider", {16'd0, divider}, 32'd0);
    check("rst_sample", {24'd0, sample}, 32'h80);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    nRst = 1'b1;

    // Saw, period 4, including wrap
    note_period = 16'd4;
    wave_sel = 2'b00;
    run_sample("saw0", 16'd0, 16'd4, 8'h00);
    run_sample("saw1", 16'd1, 16'd4, 8'h40);
    run_sample("saw2", 16'd2, 16'd4, 8'h80);
    run_sample("saw3", 16'd3, 16'd4, 8'hC0);
    run_sample("saw4", 16'd0, 16'd4, 8'h00);

    // Other shapes from phase 0
    do_reset();
    wave_sel = 2'b01;
    run_sample("sq0", 16'd0, 16'd4, 8'hFF);
    run_sample("sq1", 16'd1, 16'd4, 8'hFF);
    run_sample("sq2", 16'd2, 16'd4, 8'h00);
    run_sample("sq3", 16'd3, 16'd4, 8'h00);
    wave_sel = 2'b10;
    run_sample("tri0", 16'd0, 16'd4, 8'h00);
    run_sample("tri1", 16'd1, 16'd4, 8'h80);
    run_sample("tri2", 16'd2, 16'd4, 8'hFF);
    run_sample("tri3", 16'd3, 16'd4, 8'h7F);
    wave_sel = 2'b11;
    run_sample("fall0", 16'd0, 16'd4, 8'hFF);
    run_sample("fall1", 16'd1, 16'd4, 8'hBF);
    run_sample("fall2", 16'd2, 16'd4, 8'h7F);
    run_sample("fall3", 16'd3, 16'd4, 8'h3F);

    // Period shrink: 100 up to phase 50, then 20
    wave_sel = 2'b00;
    note_period = 16'd100;
    for (int i = 0; i < 50; i++) begin
      logic [23:0] num;
      num = 24'(i) << 8;
      run_sample("p100", 16'(i), 16'd100, 8'(num / 24'd100));
    end
    note_period = 16'd20;
    run_sample("shrink0", 16'd0, 16'd20, 8'h00);
    run_sample("shrink1", 16'd1, 16'd20, 8'h0C);

    // Silent tick
    note_period = 16'd0;
    tick_once();
    check("silent_valid", {31'd0, sample_valid}, 32'd1);
    check("silent_sample", {24'd0, sample}, 32'h80);
    check("silent_div_en", {31'd0, div_en}, 32'd0);
    nen = 0;
    nval = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (div_en) nen++;
      if (sample_valid) nval++;
    end
    check("silent_no_div_en", nen, 32'd0);
    check("silent_one_valid", nval, 32'd0);
    note_period = 16'd20;
    run_sample("after_silent", 16'd0, 16'd20, 8'h00);

    // Overrun: second tick a few cycles into the transaction
    check("pre_overrun", {31'd0, overrun}, 32'd0);
    tick_once();
    check("ovr_dividend", {16'd0, dividend}, 32'd1);
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    nval = 0;
    got_smp = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        nval++;
        got_smp = sample;
      end
    end
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_nvalid", nval, 32'd1);
    check("ovr_sample", {24'd0, got_smp}, 32'h0C);
    run_sample("after_ovr", 16'd2, 16'd20, 8'h19);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of WAIT
    tick_once();
    check("rw_dividend", {16'd0, dividend}, 32'd3);
    repeat (5) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    check("rw_div_en", {31'd0, div_en}, 32'd0);
    check("rw_dividend_rst", {16'd0, dividend}, 32'd0);
    check("rw_divider_rst", {16'd0, divider}, 32'd0);
    check("rw_sample", {24'd0, sample}, 32'h80);
    check("rw_valid", {31'd0, sample_valid}, 32'd0);
    check("rw_overrun", {31'd0, overrun}, 32'd0);
    nRst = 1'b1;
    nval = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample_valid) nval++;
    end
    check("rw_no_valid", nval, 32'd0);
    run_sample("after_rw", 16'd0, 16'd20, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
